// File: rtl/wb_arbiter_pkg.sv
// ============================================================================
// Module : wb_arbiter_pkg
// Brief  : Shared FSM encodings and widths for the write-back arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package wb_arbiter_pkg;

    localparam int REG_IDX_W = 5;
    localparam int NUM_REGS  = 32;
    localparam int CNT_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FORCE = 2'd2
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/wb_scoreboard.sv
// ============================================================================
// Module : wb_scoreboard
// Brief  : Pending-write bitmap with one set port, one clear port, two reads.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_scoreboard
    import wb_arbiter_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 set_en,
    input  logic [REG_IDX_W-1:0] set_idx,
    input  logic                 clr_en,
    input  logic [REG_IDX_W-1:0] clr_idx,
    input  logic [REG_IDX_W-1:0] rd_a_idx,
    input  logic [REG_IDX_W-1:0] rd_b_idx,
    output logic                 busy_a,
    output logic                 busy_b
);

    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_nxt;

    // Set is applied after clear so a same-cycle set on the same index wins.
    always_comb begin
        pending_nxt = pending;
        if (clr_en) begin
            pending_nxt[clr_idx] = 1'b0;
        end
        if (set_en) begin
            pending_nxt[set_idx] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    assign busy_a = pending[rd_a_idx];
    assign busy_b = pending[rd_b_idx];

endmodule

`default_nettype wire

// File: rtl/wb_arbiter.sv
// ============================================================================
// Module : wb_arbiter
// Brief  : ALU/MDU write-back arbiter with starvation guard and scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 alu_valid,
    input  logic [REG_IDX_W-1:0] alu_rd,
    input  logic [31:0]          alu_data,
    input  logic                 mdu_req,
    input  logic [REG_IDX_W-1:0] mdu_rd,
    input  logic [31:0]          mdu_data,
    output logic                 mdu_grant,
    output logic                 stall_alu,
    input  logic                 issue_valid,
    input  logic [REG_IDX_W-1:0] issue_rd,
    input  logic [9:0]           rs_rt,
    output logic                 busy_rs,
    output logic                 busy_rt,
    output logic [REG_IDX_W-1:0] rwd,
    output logic [31:0]          wb_data
);

    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             alu_grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Grants are gated by rst_n so nothing is handshaken while reset is held.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall_alu = rst_n && (state == ST_FORCE);
        mdu_grant = rst_n && mdu_req && (!alu_valid || (state == ST_FORCE));
        case (state)
            ST_IDLE: begin
                if (mdu_req && !mdu_grant) begin
                    cnt_nxt   = CNT_W'(1);
                    state_nxt = (CNT_W'(1) >= STARVE_LIM) ? ST_FORCE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!mdu_req || mdu_grant) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                    if (cnt_nxt >= STARVE_LIM) begin
                        state_nxt = ST_FORCE;
                    end
                end
            end
            ST_FORCE: begin
                cnt_nxt   = '0;
                state_nxt = ST_IDLE;
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign alu_grant = alu_valid && !stall_alu;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rwd     <= '0;
            wb_data <= '0;
        end else if (mdu_grant) begin
            rwd     <= mdu_rd;
            wb_data <= mdu_data;
        end else if (alu_grant) begin
            rwd     <= alu_rd;
            wb_data <= alu_data;
        end else begin
            rwd     <= '0;
            wb_data <= '0;
        end
    end

    wb_scoreboard u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (issue_valid),
        .set_idx  (issue_rd),
        .clr_en   (rwd != '0),
        .clr_idx  (rwd),
        .rd_a_idx (rs_rt[9:5]),
        .rd_b_idx (rs_rt[4:0]),
        .busy_a   (busy_rs),
        .busy_b   (busy_rt)
    );

endmodule

`default_nettype wire
